// File: rtl/twiddle_rotate.sv
// Multiplies a complex sample by the radix-8 twiddle W8^k using a three-stage
// pipeline: operand select/add, multiply by the 1/sqrt(2) numerator, then shift/negate/saturate.
module twiddle_rotate #(
  parameter int WIDTH  = 16,
  parameter int CMUL   = 181,
  parameter int CSHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic [2:0]              k,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int OW = WIDTH + 1;
  localparam int PW = WIDTH + 1 + $clog2(CMUL) + 1;

  localparam logic signed [PW-1:0]    CMUL_S = PW'(CMUL);
  localparam logic signed [WIDTH-1:0] SMAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN   = ~SMAX;
  localparam logic signed [PW:0]      MAXV   = {{(PW-WIDTH+1){1'b0}}, SMAX};
  localparam logic signed [PW:0]      MINV   = {{(PW-WIDTH+1){1'b1}}, SMIN};

  logic en;
  logic v1_reg;
  logic v2_reg;
  logic v3_reg;

  assign en        = ~v3_reg | out_ready;
  assign in_ready  = en;
  assign out_valid = v3_reg;

  logic signed [OW-1:0] a_w;
  logic signed [OW-1:0] b_w;
  logic signed [OW-1:0] s_w;
  logic signed [OW-1:0] d_w;
  logic signed [OW-1:0] nd_w;

  assign a_w  = {in_re[WIDTH-1], in_re};
  assign b_w  = {in_im[WIDTH-1], in_im};
  assign s_w  = a_w + b_w;
  assign d_w  = a_w - b_w;
  assign nd_w = b_w - a_w;

  // Index 0 is the real path, 1 the imaginary path. Every pre-scale negation
  // is -d, formed directly as b-a so the floor lands on the shown sign.
  logic signed [OW-1:0] sel_op    [2];
  logic                 sel_scale [2];
  logic                 sel_neg   [2];

  always_comb begin
    sel_op[0]    = a_w;
    sel_op[1]    = b_w;
    sel_scale[0] = 1'b0;
    sel_scale[1] = 1'b0;
    sel_neg[0]   = 1'b0;
    sel_neg[1]   = 1'b0;
    case (k)
      3'd0: begin
        sel_op[0] = a_w;
        sel_op[1] = b_w;
      end
      3'd1: begin
        sel_op[0] = s_w;  sel_scale[0] = 1'b1;
        sel_op[1] = nd_w; sel_scale[1] = 1'b1;
      end
      3'd2: begin
        sel_op[0] = b_w;
        sel_op[1] = a_w;  sel_neg[1] = 1'b1;
      end
      3'd3: begin
        sel_op[0] = nd_w; sel_scale[0] = 1'b1;
        sel_op[1] = s_w;  sel_scale[1] = 1'b1; sel_neg[1] = 1'b1;
      end
      3'd4: begin
        sel_op[0] = a_w;  sel_neg[0] = 1'b1;
        sel_op[1] = b_w;  sel_neg[1] = 1'b1;
      end
      3'd5: begin
        sel_op[0] = s_w;  sel_scale[0] = 1'b1; sel_neg[0] = 1'b1;
        sel_op[1] = d_w;  sel_scale[1] = 1'b1;
      end
      3'd6: begin
        sel_op[0] = b_w;  sel_neg[0] = 1'b1;
        sel_op[1] = a_w;
      end
      default: begin
        sel_op[0] = d_w;  sel_scale[0] = 1'b1;
        sel_op[1] = s_w;  sel_scale[1] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else if (en) begin
      v1_reg <= in_valid;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [OW-1:0]    op_reg;
      logic                    scale1_reg;
      logic                    neg1_reg;
      logic signed [PW-1:0]    op_ext;
      logic signed [PW-1:0]    prod_next;
      logic signed [PW-1:0]    prod_reg;
      logic                    scale2_reg;
      logic                    neg2_reg;
      logic signed [PW-1:0]    scaled_w;
      logic signed [PW:0]      ext_w;
      logic signed [PW:0]      sv_w;
      logic signed [WIDTH-1:0] res_next;
      logic signed [WIDTH-1:0] res_reg;

      assign op_ext    = {{(PW-OW){op_reg[OW-1]}}, op_reg};
      assign prod_next = scale1_reg ? (op_ext * CMUL_S) : op_ext;

      // Unscaled operands bypass the shift so they pass through exactly.
      assign scaled_w = scale2_reg ? (prod_reg >>> CSHIFT) : prod_reg;
      assign ext_w    = {scaled_w[PW-1], scaled_w};
      assign sv_w     = neg2_reg ? -ext_w : ext_w;

      always_comb begin
        if (sv_w > MAXV) begin
          res_next = SMAX;
        end else if (sv_w < MINV) begin
          res_next = SMIN;
        end else begin
          res_next = sv_w[WIDTH-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          op_reg     <= '0;
          scale1_reg <= 1'b0;
          neg1_reg   <= 1'b0;
          prod_reg   <= '0;
          scale2_reg <= 1'b0;
          neg2_reg   <= 1'b0;
          res_reg    <= '0;
        end else if (en) begin
          if (in_valid) begin
            op_reg     <= sel_op[gi];
            scale1_reg <= sel_scale[gi];
            neg1_reg   <= sel_neg[gi];
          end
          if (v1_reg) begin
            prod_reg   <= prod_next;
            scale2_reg <= scale1_reg;
            neg2_reg   <= neg1_reg;
          end
          if (v2_reg) begin
            res_reg <= res_next;
          end
        end
      end
    end
  endgenerate

  assign out_re = g_comp[0].res_reg;
  assign out_im = g_comp[1].res_reg;

endmodule

// File: tb/tb_twiddle_rotate.sv
// Directed and random checks of twiddle_rotate against a behavioural W8^k
// model, with a scoreboard queue matching accepted inputs to delivered outputs.
`timescale 1ns/1ps
module tb_twiddle_rotate;

  localparam int W      = 16;
  localparam int CMUL   = 181;
  localparam int CSHIFT = 8;

  typedef struct {
    int re;
    int im;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic [2:0]          k;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   out_cnt  = 0;
  exp_t sb_q[$];

  int da[8], db[8], dk[8], dre[8], dim[8];

  twiddle_rotate #(.WIDTH(W), .CMUL(CMUL), .CSHIFT(CSHIFT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic longint cs(input longint x);
    return (x * CMUL) >>> CSHIFT;
  endfunction

  function automatic int sat(input longint x);
    longint hi = (longint'(1) << (W-1)) - 1;
    longint lo = -(longint'(1) << (W-1));
    if (x > hi) return int'(hi);
    if (x < lo) return int'(lo);
    return int'(x);
  endfunction

  function automatic exp_t model(input int a, input int b, input int kk);
    exp_t   e;
    longint s = longint'(a) + b;
    longint d = longint'(a) - b;
    longint re, im;
    case (kk)
      0:       begin re = a;      im = b;      end
      1:       begin re = cs(s);  im = cs(-d); end
      2:       begin re = b;      im = -a;     end
      3:       begin re = cs(-d); im = -cs(s); end
      4:       begin re = -a;     im = -b;     end
      5:       begin re = -cs(s); im = cs(d);  end
      6:       begin re = -b;     im = a;      end
      default: begin re = cs(d);  im = cs(s);  end
    endcase
    e.re = sat(re);
    e.im = sat(im);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    int          r = $urandom_range(0, 9);
    logic [31:0] u = $urandom;
    if (r == 0) return {1'b1, {(W-1){1'b0}}};
    if (r == 1) return {1'b0, {(W-1){1'b1}}};
    return u[W-1:0];
  endfunction

  // Scoreboard: pop/compare on every delivered output, push on every acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          $display("out #%0d: re=%0d im=%0d (want %0d,%0d)", out_cnt, out_re, out_im, e.re, e.im);
          chk("sb_re", out_re, e.re);
          chk("sb_im", out_im, e.im);
        end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_re, in_im, k));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n, input string tag);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        in_re    = da[i][W-1:0];
        in_im    = db[i][W-1:0];
        k        = dk[i][2:0];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 2 && (i - 2) < n) begin
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_re"}, out_re, dre[i-2]);
        chk({tag, "_im"}, out_im, dim[i-2]);
      end else begin
        chk({tag, "_idle"}, out_valid, 0);
      end
    end
  endtask

  initial begin
    int idx, stall_left, base;
    bit stall_started, acc;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_re = '0; in_im = '0; k = '0;
    repeat (3) step();
    chk("rst_ov", out_valid, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    chk("rst_rdy", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    da[0] = 1000; db[0] = 0; dk[0] = 1; dre[0] = 707; dim[0] = -708;
    burst(1, "k1_basic");

    da[0] = 100; db[0] = -200; dk[0] = 0; dre[0] = 100;  dim[0] = -200;
    da[1] = 100; db[1] = -200; dk[1] = 2; dre[1] = -200; dim[1] = -100;
    da[2] = 100; db[2] = -200; dk[2] = 4; dre[2] = -100; dim[2] = 200;
    da[3] = 100; db[3] = -200; dk[3] = 6; dre[3] = 200;  dim[3] = 100;
    burst(4, "k_even");

    da[0] = 32767;  db[0] = 32767; dk[0] = 1; dre[0] = 32767; dim[0] = 0;
    da[1] = -32768; db[1] = 5;     dk[1] = 4; dre[1] = 32767; dim[1] = -5;
    burst(2, "sat");

    // Backpressure: hold each sample until accepted; stall 4 cycles after first output.
    idx = 0; stall_left = 0; stall_started = 0; base = out_cnt;
    for (int c = 0; c < 60; c++) begin
      in_valid  = (idx < 5);
      in_re     = W'(idx * 1000 + 7);
      in_im     = W'(-idx * 300);
      k         = idx[2:0];
      out_ready = (stall_left == 0);
      #1;
      acc = in_valid && in_ready;
      if (stall_left > 0) begin
        chk("bp_rdy", in_ready, 0);
        chk("bp_ov", out_valid, 1);
        if (sb_q.size() != 0) begin
          chk("bp_re_hold", out_re, sb_q[0].re);
          chk("bp_im_hold", out_im, sb_q[0].im);
        end
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (stall_left > 0) stall_left--;
      if (!stall_started && out_valid) begin
        stall_started = 1;
        stall_left    = 4;
      end
      if (idx == 5 && out_cnt - base == 5 && !out_valid) break;
    end
    chk("bp_count", out_cnt - base, 5);
    chk("bp_sb_empty", sb_q.size(), 0);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset with samples in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_re = W'(i * 11 + 3); in_im = W'(-i * 7); k = 3'(i + 3);
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    chk("mrst_ov", out_valid, 0);
    chk("mrst_re", out_re, 0);
    chk("mrst_im", out_im, 0);
    chk("mrst_rdy", in_ready, 1);
    sb_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst_stale", out_valid, 0);
    end
    in_valid = 1'b1; in_re = 16'sd1234; in_im = -16'sd321; k = 3'd3;
    step();
    in_valid = 1'b0;
    chk("post_lat1", out_valid, 0);
    step();
    chk("post_lat2", out_valid, 0);
    step();
    chk("post_lat3", out_valid, 1);
    step();

    // Random sweep with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_re     = rnd_val();
      in_im     = rnd_val();
      k         = 3'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) step();
    step();
    chk("drain_empty", sb_q.size(), 0);
    chk("drain_idle", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/twiddle_rotate.md
TWIDDLE_ROTATE -- requirements
Module: twiddle_rotate

Interface
REQ-001 Parameter WIDTH, default 16: signed two's-complement width of each real/imag component.
REQ-002 Parameter CMUL, default 181: integer numerator of the 1/sqrt(2) constant.
REQ-003 Parameter CSHIFT, default 8: right-shift paired with CMUL (c = CMUL/2^CSHIFT ≈ 0.70703).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input sample present.
REQ-007 in_ready  output  1  block accepts the input sample this cycle.
REQ-008 in_re, in_im  input  WIDTH each  complex sample a + jb.
REQ-009 k  input  3  twiddle index; selects W8^k = exp(-j*2*pi*k/8).
REQ-010 out_valid  output  1  output sample present.
REQ-011 out_ready  input  1  downstream accepts the output sample this cycle.
REQ-012 out_re, out_im  output  WIDTH each  rotated sample.

Function
REQ-013 Block SHALL be a 3-stage pipeline: S1 select/add, S2 multiply by CMUL, S3 shift/negate/saturate; each stage holds a valid bit.
REQ-014 Pipeline enable en SHALL be (~out_valid | out_ready); all stages advance together only when en=1, otherwise every stage holds its contents.
REQ-015 in_ready SHALL equal en combinationally; a sample is accepted when in_valid & in_ready.
REQ-016 Latency SHALL be exactly 3 enabled cycles from acceptance to out_valid=1; with out_ready held at 1, one sample per cycle is sustained.
REQ-017 Bubbles (cycles without an accepted input) SHALL propagate as invalid stages and are not collapsed.
REQ-018 Results, with s=a+b, d=a-b, c-scaling = (x*CMUL)>>>CSHIFT (arithmetic shift, floor): k=0 (a, b); k=1 (c*s, c*(-d)); k=2 (b, -a); k=3 (c*(-d), -c*s); k=4 (-a, -b); k=5 (-c*s, c*d); k=6 (-b, a); k=7 (c*d, c*s).
REQ-019 s and d SHALL be formed at WIDTH+1 bits, and products at WIDTH+1+log2(CMUL)+1 bits; no intermediate overflow.
REQ-020 Negation SHALL be applied to the signed operand before scaling where REQ-018 shows it inside c*( ), and after scaling otherwise; floor is thus taken on the shown sign.
REQ-021 Final components SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; -(-2^(WIDTH-1)) yields 2^(WIDTH-1)-1.
REQ-022 k SHALL be sampled with in_re/in_im at acceptance and carried down the pipeline with the data.
REQ-023 out_re/out_im SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 in_valid while in_ready=0 SHALL be ignored (no acceptance, no state change).

Reset
REQ-025 When rst=1 at a rising edge, all stage valid bits, out_valid, out_re and out_im SHALL become 0, regardless of in_valid/out_ready.
REQ-026 Reset mid-operation SHALL discard all in-flight samples; none appear after rst deasserts.
REQ-027 During and after reset, in_ready SHALL be 1 (out_valid=0).

Verification
REQ-028 a=1000, b=0, k=1, out_ready=1 -> after 3 cycles out=(707, -708), out_valid for one cycle.
REQ-029 a=100, b=-200 applied on consecutive cycles with k=0,2,4,6 -> outputs (100,-200), (-200,-100), (-100,200), (200,100) on 4 consecutive cycles.
REQ-030 Saturation: a=32767, b=32767, k=1 -> (32767, 0); a=-32768, b=5, k=4 -> (32767, -5).
REQ-031 Backpressure: stream 5 samples, drop out_ready for 4 cycles after first output -> in_ready=0 and out data frozen during stall; all 5 outputs delivered in order, none lost or duplicated.
REQ-032 Reset with 3 samples in flight -> out_valid=0, out=(0,0) next cycle; no stale output after release; next accepted sample emerges 3 cycles later.
REQ-033 Random k/a/b sweep with random out_ready against reference model of REQ-018..021 -> bit-exact match, zero mismatches.
